// File: rtl/aud_pkg.sv
// Shared definitions for the audio codec capture and playback paths.
// Holds the codec framing constants (MCLK per BCLK, BCLK per frame, the
// ADC sampling phase inside a BCLK period) and the capture FSM state type.
package aud_pkg;
  localparam int ADDR_W         = 18;
  localparam int SAMPLE_W       = 16;
  localparam int MCLK_PER_BCLK  = 48;
  localparam int BCLK_PER_FRAME = 32;
  localparam int SAMPLE_PHASE   = 36;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2
  } cap_state_e;
endpackage

// File: rtl/aud_in_capture_if.sv
// Sample-memory write bus used by the audio capture stage.
//   MEM_ADDR  : write address
//   MEM_WDATA : write data (one mono sample)
//   MEM_WE    : single-MCLK write strobe, no back-pressure
// master = capture stage (drives the bus), slave = memory side.
interface aud_in_capture_if #(
  parameter int ADDR_W   = aud_pkg::ADDR_W,
  parameter int SAMPLE_W = aud_pkg::SAMPLE_W
);
  import aud_pkg::*;

  logic [ADDR_W-1:0]   MEM_ADDR;
  logic [SAMPLE_W-1:0] MEM_WDATA;
  logic                MEM_WE;

  modport master (output MEM_ADDR, output MEM_WDATA, output MEM_WE);
  modport slave  (input  MEM_ADDR, input  MEM_WDATA, input  MEM_WE);
endinterface

// File: rtl/aud_clk_gen.sv
// Codec clock generator shared by the capture and playback paths.
// Divides MCLK into the codec bit clock and word clock and provides
// strobes aligned to the serial framing.
//   MCLK, reset   : master clock, synchronous active-high reset
//   AUD_BCLK      : registered bit clock, high for the second half of each period
//   AUD_LRCK      : registered word clock, 0 = left slot, 1 = right slot
//   sample_stb    : mid-BCLK-high sampling point of a left-slot bit
//   last_bit_stb  : sample_stb of the final (LSB) left-slot bit
//   frame_stb     : last MCLK of a frame (next cycle starts a left slot)
module aud_clk_gen #(
  parameter int MCLK_PER_BCLK  = aud_pkg::MCLK_PER_BCLK,
  parameter int BCLK_PER_FRAME = aud_pkg::BCLK_PER_FRAME,
  parameter int SAMPLE_PHASE   = aud_pkg::SAMPLE_PHASE
) (
  input  logic MCLK,
  input  logic reset,
  output logic AUD_BCLK,
  output logic AUD_LRCK,
  output logic sample_stb,
  output logic last_bit_stb,
  output logic frame_stb
);
  import aud_pkg::*;

  localparam int CW = $clog2(MCLK_PER_BCLK);
  localparam int BW = $clog2(BCLK_PER_FRAME);

  logic [CW-1:0] clk_count, clk_nxt;
  logic [BW-1:0] bclk_count, bclk_nxt;
  logic          clk_last;

  assign clk_last = (clk_count == CW'(MCLK_PER_BCLK - 1));

  // bclk_count advances on the BCLK falling edge (clk_count wrap)
  always_comb begin
    clk_nxt  = clk_last ? '0 : clk_count + 1'b1;
    bclk_nxt = bclk_count;
    if (clk_last) begin
      bclk_nxt = (bclk_count == BW'(BCLK_PER_FRAME - 1)) ? '0 : bclk_count + 1'b1;
    end
  end

  // BCLK/LRCK are registered from the next counter values so they line up
  // exactly with clk_count/bclk_count instead of lagging a cycle.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      clk_count  <= '0;
      bclk_count <= BW'(BCLK_PER_FRAME / 2);
      AUD_BCLK   <= 1'b0;
      AUD_LRCK   <= 1'b1;
    end else begin
      clk_count  <= clk_nxt;
      bclk_count <= bclk_nxt;
      AUD_BCLK   <= (clk_nxt >= CW'(MCLK_PER_BCLK / 2));
      AUD_LRCK   <= (bclk_nxt >= BW'(BCLK_PER_FRAME / 2));
    end
  end

  assign sample_stb   = (clk_count == CW'(SAMPLE_PHASE)) &&
                        (bclk_count < BW'(BCLK_PER_FRAME / 2));
  assign last_bit_stb = sample_stb && (bclk_count == BW'(BCLK_PER_FRAME / 2 - 1));
  assign frame_stb    = clk_last && (bclk_count == BW'(BCLK_PER_FRAME - 1));
endmodule

// File: rtl/aud_in_capture.sv
// Audio capture stage for the recorder path. Generates the codec clocks,
// deserializes left-justified ADC samples and writes one left-channel
// sample per frame into sample memory over [AUD_ADDR1, AUD_ADDR2).
//   MCLK, reset          : master clock, synchronous active-high reset
//   AUD_BCLK/AUD_ADCLRCK : codec bit clock / ADC word clock
//   AUD_ADCDAT           : serial ADC data, MSB first
//   AUD_ADDR1/AUD_ADDR2  : start (inclusive) / end (exclusive) address
//   enable               : record request, latched addresses on rising use
//   done                 : whole range written, stage idle
//   mem                  : sample-memory write bus (master side)
module aud_in_capture #(
  parameter int ADDR_W        = aud_pkg::ADDR_W,
  parameter int SAMPLE_W      = aud_pkg::SAMPLE_W,
  parameter int MCLK_PER_BCLK = aud_pkg::MCLK_PER_BCLK,
  parameter int SAMPLE_PHASE  = aud_pkg::SAMPLE_PHASE
) (
  input  logic              MCLK,
  input  logic              reset,
  output logic              AUD_BCLK,
  output logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  input  logic [ADDR_W-1:0] AUD_ADDR1,
  input  logic [ADDR_W-1:0] AUD_ADDR2,
  input  logic              enable,
  output logic              done,
  aud_in_capture_if.master  mem
);
  import aud_pkg::*;

  logic sample_stb, last_bit_stb, frame_stb;

  aud_clk_gen #(
    .MCLK_PER_BCLK (MCLK_PER_BCLK),
    .BCLK_PER_FRAME(BCLK_PER_FRAME),
    .SAMPLE_PHASE  (SAMPLE_PHASE)
  ) u_clk_gen (
    .MCLK        (MCLK),
    .reset       (reset),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_LRCK    (AUD_ADCLRCK),
    .sample_stb  (sample_stb),
    .last_bit_stb(last_bit_stb),
    .frame_stb   (frame_stb)
  );

  cap_state_e          state, state_nxt;
  logic                loaded;
  logic                load_req;
  logic [ADDR_W-1:0]   addr, addr_e;
  logic [SAMPLE_W-1:0] shift_p0;
  logic [SAMPLE_W-1:0] sample_full;

  // While not loaded the FSM cannot leave IDLE, so a load coinciding with a
  // frame boundary naturally defers capture to the following frame.
  assign load_req    = !loaded && enable;
  assign sample_full = {shift_p0[SAMPLE_W-2:0], AUD_ADCDAT};

  always_ff @(posedge MCLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_stb && loaded && enable && (addr < addr_e)) state_nxt = CAPTURE;
      CAPTURE: if (last_bit_stb) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial capture: shift MSB-first during the left slot
  always_ff @(posedge MCLK) begin
    if (state == CAPTURE && sample_stb) shift_p0 <= sample_full;
  end

  // Memory write and address bookkeeping
  always_ff @(posedge MCLK) begin
    if (reset) begin
      loaded        <= 1'b0;
      addr          <= '0;
      addr_e        <= '0;
      mem.MEM_WE    <= 1'b0;
      mem.MEM_ADDR  <= '0;
      mem.MEM_WDATA <= '0;
    end else begin
      mem.MEM_WE <= 1'b0;
      if (state == IDLE) begin
        if (load_req) begin
          addr   <= AUD_ADDR1;
          addr_e <= AUD_ADDR2;
          loaded <= 1'b1;
        end else if (!enable) begin
          loaded <= 1'b0;
        end
      end
      // Bus is loaded on the LSB sample so WE coincides with the WRITE state;
      // address/data then hold until the next write.
      if (state == CAPTURE && last_bit_stb) begin
        mem.MEM_WE    <= 1'b1;
        mem.MEM_WDATA <= sample_full;
        mem.MEM_ADDR  <= addr;
      end
      if (state == WRITE) addr <= addr + 1'b1;
    end
  end

  assign done = loaded && (addr == addr_e) && (state == IDLE);
endmodule

// File: tb/tb_aud_in_capture.sv
module tb_aud_in_capture;
  logic        MCLK = 1'b0;
  logic        reset = 1'b1;
  logic        AUD_ADCDAT = 1'b0;
  logic        enable = 1'b0;
  logic        AUD_BCLK, AUD_ADCLRCK, done;
  logic [17:0] AUD_ADDR1 = '0, AUD_ADDR2 = '0;

  aud_in_capture_if mem_if ();

  aud_in_capture dut (
    .MCLK       (MCLK),
    .reset      (reset),
    .AUD_BCLK   (AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT (AUD_ADCDAT),
    .AUD_ADDR1  (AUD_ADDR1),
    .AUD_ADDR2  (AUD_ADDR2),
    .enable     (enable),
    .done       (done),
    .mem        (mem_if)
  );

  always #5 MCLK = ~MCLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge MCLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  // Codec model: left-justified, MSB driven right after each BCLK fall
  // that opens a slot. mode 0 = fixed words, 1 = random, 2 = 0x8000/0x0001.
  int          mode = 0;
  logic [15:0] fix_left = '0, fix_right = '0, cur_left = '0, cur_right = '0;
  logic        alt_sel = 1'b0;
  logic        prev_bclk = 1'b0, prev_lrck = 1'b1;
  int          bit_idx = 0;
  int          lrck_fall_cyc = -1;
  logic [15:0] word;

  always @(posedge MCLK) begin
    #1;
    if (prev_bclk && !AUD_BCLK) begin
      if (AUD_ADCLRCK != prev_lrck) begin
        bit_idx = 0;
        if (!AUD_ADCLRCK) begin
          lrck_fall_cyc = cyc;
          case (mode)
            0: begin cur_left = fix_left; cur_right = fix_right; end
            1: begin cur_left = 16'($urandom); cur_right = 16'($urandom); end
            default: begin
              cur_left  = alt_sel ? 16'h0001 : 16'h8000;
              alt_sel   = !alt_sel;
              cur_right = 16'($urandom);
            end
          endcase
        end
      end else begin
        bit_idx++;
      end
    end
    word = AUD_ADCLRCK ? cur_right : cur_left;
    AUD_ADCDAT = (bit_idx < 16) ? word[4'(15 - bit_idx)] : 1'b0;
    prev_bclk = AUD_BCLK;
    prev_lrck = AUD_ADCLRCK;
  end

  // Scoreboard: each write carries the current left word, sequential address,
  // lands 757 MCLK into the left slot, and consecutive writes are one frame apart.
  int          wr_count = 0;
  logic [17:0] exp_addr = '0;
  int          last_we_cyc = -1;
  logic        prev_we = 1'b0;
  logic [15:0] wdata_q[$];

  always @(negedge MCLK) begin
    if (mem_if.MEM_WE === 1'b1) begin
      chk("we_one_cycle", 32'(prev_we), 32'd0);
      chk("wr_addr", 32'(mem_if.MEM_ADDR), 32'(exp_addr));
      chk("wr_data", 32'(mem_if.MEM_WDATA), 32'(cur_left));
      chk("wr_latency", 32'(cyc - lrck_fall_cyc), 32'd757);
      if (last_we_cyc >= 0) chk("wr_spacing", 32'(cyc - last_we_cyc), 32'd1536);
      last_we_cyc = cyc;
      exp_addr    = exp_addr + 18'd1;
      wr_count++;
      wdata_q.push_back(mem_if.MEM_WDATA);
    end
    prev_we = mem_if.MEM_WE;
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return AUD_BCLK;
      1:       return AUD_ADCLRCK;
      default: return done;
    endcase
  endfunction

  // sel 0/1: wait for an edge to lvl on BCLK/LRCK; sel 2: wait for done==lvl
  task automatic wait_sig(input int sel, input logic lvl, input int bound,
                          input string tag, output int at);
    logic p;
    p  = sig(sel);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (sig(sel) === lvl && (p !== lvl || sel == 2)) begin
        at = cyc;
        break;
      end
      p = sig(sel);
    end
    checks++;
    assert (at >= 0) else begin
      errors++;
      $error("FAIL %s_timeout: observed=none in %0d cycles expected=event", tag, bound);
    end
  endtask

  task automatic wait_writes(input int target, input int bound, input string tag);
    int i;
    for (i = 0; i < bound && wr_count < target; i++) tick(1);
    checks++;
    assert (wr_count >= target) else begin
      errors++;
      $error("FAIL %s_timeout: observed=%0d writes expected=%0d", tag, wr_count, target);
    end
  endtask

  initial begin
    int base, t_first, t0, t1, t2, wr_base;

    // Reset values and free-running clock timing
    mode = 0; fix_left = 16'hA5C3; fix_right = 16'hFFFF;
    reset = 1'b1; enable = 1'b0;
    tick(3);
    chk("rst_bclk",  32'(AUD_BCLK), 32'd0);
    chk("rst_lrck",  32'(AUD_ADCLRCK), 32'd1);
    chk("rst_we",    32'(mem_if.MEM_WE), 32'd0);
    chk("rst_addr",  32'(mem_if.MEM_ADDR), 32'd0);
    chk("rst_wdata", 32'(mem_if.MEM_WDATA), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    reset = 1'b0;
    base  = cyc;
    wait_sig(1, 1'b0, 2000, "first_lrck", t_first);
    chk("first_lrck_fall", 32'(t_first - base), 32'd768);
    wait_sig(0, 1'b1, 200, "bclk_rise", t1);
    wait_sig(0, 1'b0, 200, "bclk_fall", t2);
    chk("bclk_high", 32'(t2 - t1), 32'd24);
    wait_sig(0, 1'b1, 200, "bclk_rise2", t0);
    chk("bclk_period", 32'(t0 - t1), 32'd48);
    wait_sig(1, 1'b0, 2000, "lrck_fall2", t0);
    chk("lrck_period", 32'(t0 - t_first), 32'd1536);

    // Three-word recording of a fixed left word
    AUD_ADDR1 = 18'h00010; AUD_ADDR2 = 18'h00013;
    exp_addr = 18'h00010; last_we_cyc = -1; wr_base = wr_count;
    enable = 1'b1;
    wait_sig(2, 1'b1, 8000, "t2_done", t0);
    chk("t2_writes", 32'(wr_count - wr_base), 32'd3);
    chk("t2_done_lat", 32'(t0 - last_we_cyc), 32'd1);
    tick(3200);
    chk("t2_no_extra", 32'(wr_count - wr_base), 32'd3);
    chk("t2_done_hold", 32'(done), 32'd1);
    chk("t2_addr_hold", 32'(mem_if.MEM_ADDR), 32'h12);
    chk("t2_data_hold", 32'(mem_if.MEM_WDATA), 32'hA5C3);

    // Empty range: done right after load, nothing written
    enable = 1'b0;
    tick(1);
    chk("t3_done_cleared", 32'(done), 32'd0);
    AUD_ADDR1 = 18'h00020; AUD_ADDR2 = 18'h00020;
    enable = 1'b1;
    chk("t3_done_pre_load", 32'(done), 32'd0);
    tick(1);
    chk("t3_done_post_load", 32'(done), 32'd1);
    wr_base = wr_count;
    tick(3200);
    chk("t3_no_writes", 32'(wr_count - wr_base), 32'd0);

    // enable dropped mid-capture: that frame completes, then recording stops
    enable = 1'b0;
    tick(2);
    mode = 1;
    AUD_ADDR1 = 18'h00040; AUD_ADDR2 = 18'h00050;
    exp_addr = 18'h00040; last_we_cyc = -1; wr_base = wr_count;
    enable = 1'b1;
    wait_writes(wr_base + 1, 4000, "t4_first");
    wait_sig(1, 1'b0, 2000, "t4_lrck", t0);
    tick(5 * 48);
    enable = 1'b0;
    wait_writes(wr_base + 2, 1600, "t4_inflight");
    tick(3200);
    chk("t4_writes_after_drop", 32'(wr_count - wr_base), 32'd2);
    chk("t4_done_low", 32'(done), 32'd0);
    AUD_ADDR1 = 18'h00100; AUD_ADDR2 = 18'h00102;
    exp_addr = 18'h00100; last_we_cyc = -1; wr_base = wr_count;
    enable = 1'b1;
    wait_sig(2, 1'b1, 6000, "t4_resume_done", t0);
    chk("t4_resume_writes", 32'(wr_count - wr_base), 32'd2);
    chk("t4_resume_addr", 32'(mem_if.MEM_ADDR), 32'h101);

    // Reset in the middle of a capture discards the partial sample
    enable = 1'b0;
    tick(2);
    AUD_ADDR1 = 18'h00200; AUD_ADDR2 = 18'h00210;
    exp_addr = 18'h00200; last_we_cyc = -1; wr_base = wr_count;
    enable = 1'b1;
    wait_writes(wr_base + 1, 4000, "t5_first");
    wait_sig(1, 1'b0, 2000, "t5_lrck", t0);
    tick(10 * 48);
    reset = 1'b1; enable = 1'b0;
    tick(3);
    chk("t5_rst_we", 32'(mem_if.MEM_WE), 32'd0);
    chk("t5_rst_addr", 32'(mem_if.MEM_ADDR), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick(1600);
    chk("t5_no_write", 32'(wr_count - wr_base), 32'd1);
    chk("t5_addr_stays", 32'(mem_if.MEM_ADDR), 32'd0);
    chk("t5_done_low", 32'(done), 32'd0);
    AUD_ADDR1 = 18'h00037; AUD_ADDR2 = 18'h00037;
    enable = 1'b1;
    tick(1);
    chk("t5_reload_done", 32'(done), 32'd1);
    enable = 1'b0;
    tick(2);

    // Alternating 0x8000 / 0x0001 left words (bit ordering)
    mode = 2; alt_sel = 1'b0;
    AUD_ADDR1 = 18'h00300; AUD_ADDR2 = 18'h00304;
    exp_addr = 18'h00300; last_we_cyc = -1; wr_base = wr_count;
    enable = 1'b1;
    wait_sig(2, 1'b1, 9000, "t6_done", t0);
    chk("t6_writes", 32'(wr_count - wr_base), 32'd4);
    if (wdata_q.size() >= 2)
      chk("t6_alternate", 32'(wdata_q[wdata_q.size()-2] ^ wdata_q[wdata_q.size()-1]), 32'h8001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aud_in_capture.md
# aud_in_capture

Audio capture stage for the recorder path: generates codec bit clock and ADC word clock from MCLK, deserializes 16-bit left-justified ADC samples, and writes one mono (left-channel) sample per frame into sample memory between a start and an end address. It sits upstream of the memory interface and is the recording counterpart of the playback serializer, which later reads the same address range back out.

## Interface
Parameters:
- ADDR_W, 18, memory address width
- SAMPLE_W, 16, sample width / bits per slot
- MCLK_PER_BCLK, 48, MCLK cycles per BCLK period
- SAMPLE_PHASE, 36, clk_count value at which AUD_ADCDAT is sampled (mid BCLK-high)

Ports:
- MCLK  in  1  12.288 MHz master clock, sole clock domain
- reset  in  1  synchronous, active-high reset
- AUD_BCLK  out  1  codec bit clock, 256 kHz, registered
- AUD_ADCLRCK  out  1  ADC word clock; 0 = left slot, 1 = right slot
- AUD_ADCDAT  in  1  serial ADC data, MSB first
- AUD_ADDR1  in  18  start address (inclusive)
- AUD_ADDR2  in  18  end address (exclusive)
- MEM_ADDR  out  18  write address
- MEM_WDATA  out  16  write data
- MEM_WE  out  1  one-MCLK write strobe
- enable  in  1  record request
- done  out  1  range fully written

## Operation
- Clock gen: clk_count 0..47 wraps; AUD_BCLK = 1 for clk_count 24..47. bclk_count 0..31 increments on clk_count 47→0 (BCLK falling). AUD_ADCLRCK = bclk_count[4]. Clocks free-run regardless of enable. Frame = 32 BCLK = 8 kHz.
- Load: when !loaded and enable: addr←AUD_ADDR1, addr_e←AUD_ADDR2, loaded←1.
- FSM states IDLE, CAPTURE, WRITE.
  - IDLE→CAPTURE at frame boundary (bclk_count=31, clk_count=47) when loaded, enable, addr<addr_e.
  - IDLE with enable=0: loaded←0 (re-arm on next enable).
  - CAPTURE: at clk_count=SAMPLE_PHASE during bclk_count 0..15, shift AUD_ADCDAT into shift reg LSB (MSB first). After bit 15 (bclk_count=15) → WRITE.
  - WRITE: one cycle; MEM_WE=1, MEM_WDATA=shift reg, MEM_ADDR=addr; next cycle addr←addr+1, → IDLE.
- Right slot (bclk_count 16..31) ignored.
- enable is evaluated only in IDLE; deasserting during CAPTURE lets that frame's write complete.
- done = loaded & (addr==addr_e) & state==IDLE.
- addr never exceeds addr_e; AUD_ADDR2 < AUD_ADDR1 → no writes, done stays 0.

## Timing
- Reset (synchronous): clk_count=0, bclk_count=16, AUD_BCLK=0, AUD_ADCLRCK=1, state=IDLE, loaded=0, addr=0, addr_e=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, done=0.
- Reset mid-CAPTURE/WRITE: partial sample discarded, no MEM_WE.
- First left slot starts 16 BCLK (768 MCLK) after reset release.
- Sample latency: MEM_WE asserted 1 MCLK after bit-15 sample, i.e. at bclk_count=15, clk_count=37.
- MEM_ADDR/MEM_WDATA held stable from WE cycle until next write; memory must accept in the single WE cycle (no back-pressure).
- Writes spaced exactly 1536 MCLK apart while recording.
- Load and frame boundary in same cycle: load takes priority, capture starts next frame.

## Structure
- Shared package aud_pkg: ADDR_W, SAMPLE_W, MCLK_PER_BCLK, BCLK_PER_FRAME=32, SAMPLE_PHASE, FSM state enum.
- Sub-module aud_clk_gen: clk_count/bclk_count counters, AUD_BCLK, LRCK, sample and frame-boundary strobes; reusable by the playback path.

## Test plan
- Reset held 3 cycles → all outputs at reset values; first LRCK fall after 768 MCLK; BCLK period 48 (24 high), LRCK period 1536 MCLK.
- ADDR1=0x00010, ADDR2=0x00013, enable=1, ADC left=0xA5C3, right=0xFFFF → exactly 3 MEM_WE pulses at 0x00010/11/12, data 0xA5C3, 1536 MCLK apart; done=1 after third, no further writes.
- ADDR1=ADDR2=0x00020 → no MEM_WE; done=1 one cycle after load.
- enable dropped at bclk_count=5 of a frame → that frame's write still issued; then no writes, done=0; enable re-raised with ADDR1=0x00100 → writes resume at 0x00100.
- reset asserted at bclk_count=10 during CAPTURE → no MEM_WE for that frame, addr=0, loaded=0.
- Alternating left samples 0x8000/0x0001 → MEM_WDATA exact per frame (MSB-first ordering check).
